// File: rtl/sumador_8bit.sv
// -----------------------------------------------------------------------------
// sumador_8bit
//
// Registered adder for the processor datapath. Both operands are sampled on
// every rising clock edge, and the sum and its flags are presented one cycle
// later from flops, so downstream logic never sees combinational glitches.
//
// Ports:
//   clk        rising-edge clock, the only clock
//   rst_n      asynchronous, active-low reset; clears every output at once
//   inA, inB   operands (unsigned or two's complement)
//   sum        (inA + inB) mod 2^WIDTH
//   sum_sat    unsigned saturating sum, min(inA + inB, 2^WIDTH - 1)
//   cout       unsigned carry-out (top bit of the WIDTH+1 bit sum)
//   ovf        signed overflow: operand signs equal, result sign differs
//   zero       1 when the wrapped sum is 0 (forced to 0 during reset)
//   neg        sign bit of the wrapped sum
//   out_valid  1 once the outputs hold a result computed from sampled inputs
//
// Handshake: there is none on the input side. A new result is produced on
// every edge. out_valid is a plain status bit, not a valid/ready handshake:
// it rises on the first edge after reset release and stays high until the
// next reset.
// -----------------------------------------------------------------------------
module sumador_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] sum_sat,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             out_valid
);

  // Combinational stage: zero-extended add, carry-in fixed at 0.
  logic [WIDTH:0]   w_full;
  logic [WIDTH-1:0] w_wrap;
  logic             w_ovf;

  assign w_full = {1'b0, inA} + {1'b0, inB};
  assign w_wrap = w_full[WIDTH-1:0];

  // Signed overflow can only happen when both operands share a sign and the
  // wrapped result comes out with the other sign.
  assign w_ovf = (inA[WIDTH-1] == inB[WIDTH-1]) &&
                 (w_wrap[WIDTH-1] != inA[WIDTH-1]);

  // Register stage.
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_sum_sat;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;
  logic             r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_sum_sat   <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      // zero reads 0 during reset even though the sum is 0.
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_sum       <= w_wrap;
      r_sum_sat   <= w_full[WIDTH] ? {WIDTH{1'b1}} : w_wrap;
      r_cout      <= w_full[WIDTH];
      r_ovf       <= w_ovf;
      // Taken from the wrapped sum, so a carry-out with all-zero low bits
      // still reports zero.
      r_zero      <= (w_wrap == '0);
      r_neg       <= w_wrap[WIDTH-1];
      r_out_valid <= 1'b1;
    end
  end

  assign sum       = r_sum;
  assign sum_sat   = r_sum_sat;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sumador_8bit.sv
// -----------------------------------------------------------------------------
// tb_sumador_8bit
//
// Bench for the registered adder. All outputs are packed into one vector
// {sum, sum_sat, cout, ovf, zero, neg, out_valid}. Expected vectors come from
// an integer arithmetic model and are queued when the operands are driven,
// then popped and compared one edge later.
// -----------------------------------------------------------------------------
module tb_sumador_8bit;

  localparam int W  = 8;
  localparam int OW = 2 * W + 5;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic [W-1:0] sum;
  logic [W-1:0] sum_sat;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;
  logic         out_valid;

  sumador_8bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inA       (inA),
    .inB       (inB),
    .sum       (sum),
    .sum_sat   (sum_sat),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg),
    .out_valid (out_valid)
  );

  logic [OW-1:0] dut_vec;
  assign dut_vec = {sum, sum_sat, cout, ovf, zero, neg, out_valid};

  // ---------------------------------------------------------------- scoreboard
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] last_exp;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag, input logic [OW-1:0] got,
                       input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic logic [OW-1:0] model(input int a, input int b);
    int           u;
    int           s;
    logic [W-1:0] w;
    logic [W-1:0] sat;
    logic         c;
    logic         o;
    u   = a + b;
    w   = W'(u % 256);
    c   = (u > 255);
    sat = c ? W'(255) : w;
    s   = (a > 127 ? a - 256 : a) + (b > 127 ? b - 256 : b);
    o   = (s > 127) || (s < -128);
    return {w, sat, c, o, (w == 0), w[W-1], 1'b1};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic send(input int a, input int b);
    inA = W'(a);
    inB = W'(b);
    exp_q.push_back(model(a, b));
  endtask

  task automatic collect(input string tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      last_exp = exp_q.pop_front();
      check(tag, dut_vec, last_exp);
    end
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    inA      = 8'd10;
    inB      = 8'd20;

    // Reset held: outputs stay cleared through clock edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", dut_vec, '0);
    end

    // Release between edges, first edge loads 10+20.
    #3;
    rst_n = 1'b1;
    send(10, 20);
    collect("reset_release");

    // Basic sequence.
    send(0, 0);
    collect("basic_0");
    send(10, 0);
    collect("basic_10");
    send(20, 0);
    collect("basic_20");

    // Unsigned wrap and signed overflow corners.
    send(200, 100);
    collect("unsigned_wrap");
    send(100, 50);
    collect("signed_ovf");
    send(128, 128);
    collect("ovf_zero_carry");
    send(255, 255);
    collect("max_plus_max");
    send(127, 1);
    collect("pos_to_neg");
    send(255, 0);
    collect("no_carry_max");

    // Mid-run reset: clears asynchronously, pending result discarded.
    send(255, 1);
    collect("wrap_to_zero");
    send(255, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec, '0);
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    send(255, 1);
    collect("reload_after_reset");

    // Latency: input change between edges must not reach the outputs.
    send(33, 44);
    #3;
    check("hold_between_edges", dut_vec, last_exp);
    collect("latency_new");

    // Constant inputs hold outputs.
    send(33, 44);
    collect("hold_const");

    // Random back-to-back traffic.
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      collect("random");
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL leftover expected=%0d", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
